i3c_phy_mux_ctrl: RTL and testbench

Sequential ownership controller for the 4-to-1 PHY mux. It drives the mux select from the opposite end: it takes bus-ownership requests from up to four controllers, watches the shared SCL/SDA lines, and moves ownership only when the bus is free. It issues a one-hot grant, so a controller never gains or loses the PHY mid-transaction.

---
 rtl/i3c_phy_mux_ctrl.sv | 135 +++++++++++++
 tb/tb_i3c_phy_mux_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/i3c_phy_mux_ctrl.sv
// -----------------------------------------------------------------------------
// i3c_phy_mux_ctrl
//
// Ownership controller for the 4-to-1 I3C PHY mux. It collects level requests
// from up to four controllers and watches the shared SCL/SDA lines. Ownership
// moves only after the bus has been idle (SCL=SDA=1) for a programmable number
// of cycles, so a controller never gains or loses the PHY mid-transaction.
//
// Ports:
//   clk_i            core clock
//   rst_i            synchronous reset, active-high
//   req_i            per-controller ownership request (level)
//   phy_scl_i        SCL at the PHY, already synchronized to clk_i
//   phy_sda_i        SDA at the PHY, already synchronized to clk_i
//   bus_free_thld_i  consecutive idle cycles required before a handover
//   select_o         mux select: index of the current/next owner
//   grant_o          one-hot ownership grant, all-zero when unowned
//   bus_free_o       bus-free condition met this cycle (combinational)
//   switching_o      high during the one-cycle mux-settling guard
// -----------------------------------------------------------------------------
module i3c_phy_mux_ctrl #(
    parameter int unsigned NumCtrl  = 4,
    parameter int unsigned IdleCntW = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumCtrl-1:0]  req_i,
    input  logic                phy_scl_i,
    input  logic                phy_sda_i,
    input  logic [IdleCntW-1:0] bus_free_thld_i,
    output logic [1:0]          select_o,
    output logic [NumCtrl-1:0]  grant_o,
    output logic                bus_free_o,
    output logic                switching_o
);

    typedef enum logic [1:0] {
        StWaitFree = 2'b00,
        StSwitch   = 2'b01,
        StGranted  = 2'b10
    } state_e;

    localparam logic [IdleCntW-1:0] CntMax = {IdleCntW{1'b1}};

    state_e               r_state;
    logic [1:0]           r_sel;
    logic [NumCtrl-1:0]   r_grant;
    logic                 r_switching;
    logic [IdleCntW-1:0]  r_idle_cnt;

    logic                 w_lines_high;
    logic                 w_bus_free;
    logic                 w_win_valid;
    logic [1:0]           w_win_idx;
    logic [1:0]           w_cand;
    logic [NumCtrl-1:0]   w_sel_onehot;

    assign w_lines_high = phy_scl_i & phy_sda_i;
    assign w_bus_free   = w_lines_high & (r_idle_cnt >= bus_free_thld_i);
    assign w_sel_onehot = NumCtrl'(1) << r_sel;

    // Idle counter runs in every state and saturates rather than wrapping, so a
    // long-idle bus stays free even with the maximum threshold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idle_cnt <= '0;
        end else if (!w_lines_high) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != CntMax) begin
            r_idle_cnt <= r_idle_cnt + IdleCntW'(1);
        end
    end

    // Round-robin scan select+1, +2, +3, +0. Walking the offsets from farthest
    // to nearest lets the nearest requester overwrite the others, so the
    // current owner is only ever the last candidate.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = r_sel;
        w_cand      = r_sel;
        for (int i = NumCtrl; i >= 1; i--) begin
            w_cand = r_sel + 2'(i);
            if (req_i[w_cand]) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= StWaitFree;
            r_sel       <= 2'd0;
            r_grant     <= '0;
            r_switching <= 1'b0;
        end else begin
            case (r_state)
                StWaitFree: begin
                    r_grant     <= '0;
                    r_switching <= 1'b0;
                    if (w_bus_free && w_win_valid) begin
                        r_state     <= StSwitch;
                        r_sel       <= w_win_idx;
                        r_switching <= 1'b1;
                    end
                end
                // Guard cycle: the mux select has moved but nobody is granted yet.
                StSwitch: begin
                    r_state     <= StGranted;
                    r_switching <= 1'b0;
                    r_grant     <= w_sel_onehot;
                end
                // No preemption: only the owner's own release ends the grant.
                StGranted: begin
                    r_switching <= 1'b0;
                    if (!req_i[r_sel]) begin
                        r_state <= StWaitFree;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state     <= StWaitFree;
                    r_grant     <= '0;
                    r_switching <= 1'b0;
                end
            endcase
        end
    end

    assign select_o    = r_sel;
    assign grant_o     = r_grant;
    assign bus_free_o  = w_bus_free;
    assign switching_o = r_switching;

endmodule

// File: tb/tb_i3c_phy_mux_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i3c_phy_mux_ctrl
//
// Bench for i3c_phy_mux_ctrl. Each cycle's inputs are driven just after the
// rising edge; the expected outputs for that cycle go into a queue and are
// popped and compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_i3c_phy_mux_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        scl;
    logic        sda;
    logic [15:0] thld;
    logic [1:0]  select;
    logic [3:0]  grant;
    logic        bus_free;
    logic        switching;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        scl;
        logic        sda;
        logic [15:0] thld;
        int          n;
        logic        chk;
        logic [1:0]  sel;
        logic [3:0]  grant;
        logic        free;
        logic        sw;
    } vec_t;

    typedef struct {
        logic        chk;
        logic [1:0]  sel;
        logic [3:0]  grant;
        logic        free;
        logic        sw;
        string       tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    i3c_phy_mux_ctrl #(
        .NumCtrl  (4),
        .IdleCntW (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req),
        .phy_scl_i       (scl),
        .phy_sda_i       (sda),
        .bus_free_thld_i (thld),
        .select_o        (select),
        .grant_o         (grant),
        .bus_free_o      (bus_free),
        .switching_o     (switching)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic c, input logic d,
                       input logic [15:0] th, input int n, input logic chk,
                       input logic [1:0] s, input logic [3:0] g, input logic f,
                       input logic w);
        vec_t v;
        v.rst = r; v.req = rq; v.scl = c; v.sda = d; v.thld = th; v.n = n;
        v.chk = chk; v.sel = s; v.grant = g; v.free = f; v.sw = w;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive, queue the expectation, sample mid-cycle.
    task automatic step(input logic r, input logic [3:0] rq, input logic c, input logic d,
                        input logic [15:0] th, input logic chk, input logic [1:0] s,
                        input logic [3:0] g, input logic f, input logic w,
                        input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; req = rq; scl = c; sda = d; thld = th;
        e.chk = chk; e.sel = s; e.grant = g; e.free = f; e.sw = w; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            if (e.chk) begin
                check({e.tag, ".select"},   16'(select),    16'(e.sel));
                check({e.tag, ".grant"},    16'(grant),     16'(e.grant));
                check({e.tag, ".bus_free"}, 16'(bus_free),  16'(e.free));
                check({e.tag, ".switch"},   16'(switching), 16'(e.sw));
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; scl = 1'b1; sda = 1'b1; thld = 16'd5;

        // Reset, first grant to controller 2, then no preemption and handover to 0.
        //   rst   req      scl   sda   thld   n  chk  sel   grant    free  sw
        add(1'b1, 4'b0000, 1'b1, 1'b1, 16'd5, 2, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 4'b0100, 1'b1, 1'b1, 16'd5, 5, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 4'b0100, 1'b1, 1'b1, 16'd5, 1, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b0);
        add(1'b0, 4'b0100, 1'b1, 1'b1, 16'd5, 1, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b1);
        add(1'b0, 4'b0100, 1'b1, 1'b1, 16'd5, 1, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0);
        add(1'b0, 4'b0101, 1'b1, 1'b1, 16'd5, 2, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 16'd5, 1, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b1, 16'd5, 5, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b1, 16'd5, 1, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 1'b1, 16'd5, 1, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b1);
        add(1'b0, 4'b0001, 1'b1, 1'b1, 16'd5, 1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                step(vecs[i].rst, vecs[i].req, vecs[i].scl, vecs[i].sda, vecs[i].thld,
                     vecs[i].chk, vecs[i].sel, vecs[i].grant, vecs[i].free, vecs[i].sw,
                     $sformatf("tbl%0d.%0d", i, k));
            end
        end

        // SDA glitch at idle count 3 restarts the full idle wait.
        step(0, 4'b0000, 1, 0, 16'd5, 1, 2'd0, 4'b0001, 0, 0, "glitch.rel");
        step(0, 4'b0010, 1, 1, 16'd5, 1, 2'd0, 4'b0000, 0, 0, "glitch.c0");
        step(0, 4'b0010, 1, 1, 16'd5, 1, 2'd0, 4'b0000, 0, 0, "glitch.c1");
        step(0, 4'b0010, 1, 1, 16'd5, 1, 2'd0, 4'b0000, 0, 0, "glitch.c2");
        step(0, 4'b0010, 1, 0, 16'd5, 1, 2'd0, 4'b0000, 0, 0, "glitch.low");
        for (int i = 0; i < 5; i++)
            step(0, 4'b0010, 1, 1, 16'd5, 1, 2'd0, 4'b0000, 0, 0, $sformatf("glitch.w%0d", i));
        step(0, 4'b0010, 1, 1, 16'd5, 1, 2'd0, 4'b0000, 1, 0, "glitch.free");
        step(0, 4'b0010, 1, 1, 16'd5, 1, 2'd1, 4'b0000, 1, 1, "glitch.sw");
        step(0, 4'b0010, 1, 1, 16'd5, 1, 2'd1, 4'b0010, 1, 0, "glitch.gnt");

        // All four requesting from select 1: winners 2, 3, 0, 1 (threshold 0).
        step(0, 4'b1101, 1, 1, 16'd0, 1, 2'd1, 4'b0010, 1, 0, "rr.rel1");
        step(0, 4'b1111, 1, 1, 16'd0, 1, 2'd1, 4'b0000, 1, 0, "rr.wf2");
        step(0, 4'b1111, 1, 1, 16'd0, 1, 2'd2, 4'b0000, 1, 1, "rr.sw2");
        step(0, 4'b1111, 1, 1, 16'd0, 1, 2'd2, 4'b0100, 1, 0, "rr.g2");
        step(0, 4'b1011, 1, 1, 16'd0, 1, 2'd2, 4'b0100, 1, 0, "rr.rel2");
        step(0, 4'b1011, 1, 1, 16'd0, 1, 2'd2, 4'b0000, 1, 0, "rr.wf3");
        step(0, 4'b1011, 1, 1, 16'd0, 1, 2'd3, 4'b0000, 1, 1, "rr.sw3");
        step(0, 4'b1011, 1, 1, 16'd0, 1, 2'd3, 4'b1000, 1, 0, "rr.g3");
        step(0, 4'b0011, 1, 1, 16'd0, 1, 2'd3, 4'b1000, 1, 0, "rr.rel3");
        step(0, 4'b0011, 1, 1, 16'd0, 1, 2'd3, 4'b0000, 1, 0, "rr.wf0");
        step(0, 4'b0011, 1, 1, 16'd0, 1, 2'd0, 4'b0000, 1, 1, "rr.sw0");
        step(0, 4'b0011, 1, 1, 16'd0, 1, 2'd0, 4'b0001, 1, 0, "rr.g0");
        step(0, 4'b0010, 1, 1, 16'd0, 1, 2'd0, 4'b0001, 1, 0, "rr.rel0");
        step(0, 4'b0010, 1, 1, 16'd0, 1, 2'd0, 4'b0000, 1, 0, "rr.wf1");
        step(0, 4'b0010, 1, 1, 16'd0, 1, 2'd1, 4'b0000, 1, 1, "rr.sw1");
        step(0, 4'b0010, 1, 1, 16'd0, 1, 2'd1, 4'b0010, 1, 0, "rr.g1");

        // Previous owner re-wins as the only candidate, still via the guard cycle.
        step(0, 4'b0000, 1, 1, 16'd0, 1, 2'd1, 4'b0010, 1, 0, "self.rel");
        step(0, 4'b0010, 1, 1, 16'd0, 1, 2'd1, 4'b0000, 1, 0, "self.wf");
        step(0, 4'b0010, 1, 1, 16'd0, 1, 2'd1, 4'b0000, 1, 1, "self.sw");
        step(0, 4'b0010, 1, 1, 16'd0, 1, 2'd1, 4'b0010, 1, 0, "self.g");

        // Reset while controller 3 owns the PHY.
        step(0, 4'b1000, 1, 1, 16'd0, 1, 2'd1, 4'b0010, 1, 0, "rst.rel1");
        step(0, 4'b1000, 1, 1, 16'd0, 1, 2'd1, 4'b0000, 1, 0, "rst.wf3");
        step(0, 4'b1000, 1, 1, 16'd0, 1, 2'd3, 4'b0000, 1, 1, "rst.sw3");
        step(0, 4'b1000, 1, 1, 16'd0, 1, 2'd3, 4'b1000, 1, 0, "rst.g3");
        step(1, 4'b1000, 1, 1, 16'd0, 1, 2'd3, 4'b1000, 1, 0, "rst.assert");
        step(0, 4'b0000, 1, 1, 16'd0, 1, 2'd0, 4'b0000, 1, 0, "rst.after");

        // Winner drops its request during the guard cycle.
        step(0, 4'b0001, 1, 1, 16'd0, 1, 2'd0, 4'b0000, 1, 0, "drop.wf");
        step(0, 4'b0000, 1, 1, 16'd0, 1, 2'd0, 4'b0000, 1, 1, "drop.sw");
        step(0, 4'b0000, 1, 1, 16'd0, 1, 2'd0, 4'b0001, 1, 0, "drop.g");
        step(0, 4'b0000, 1, 1, 16'd0, 1, 2'd0, 4'b0000, 1, 0, "drop.wf2");

        // Threshold 0 still needs both lines high.
        step(0, 4'b0000, 0, 1, 16'd0, 1, 2'd0, 4'b0000, 0, 0, "thld0.scl_low");

        // Saturation: max threshold is reached after 65535 idle cycles and holds.
        step(0, 4'b0000, 1, 0, 16'hFFFF, 1, 2'd0, 4'b0000, 0, 0, "sat.clr");
        for (int m = 0; m <= 70000; m++) begin
            step(0, 4'b0000, 1, 1, 16'hFFFF, (m < 3) || (m >= 65530),
                 2'd0, 4'b0000, (m >= 65535), 0, $sformatf("sat.m%0d", m));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
